// File: rtl/keccak_feeder_pkg.sv
// Shared types and constants for the keccak byte feeder.
package keccak_feeder_pkg;

    localparam int WORD_BYTES = 8;
    localparam int BYTE_NUM_W = 3;
    localparam int CNT_W      = 4;

    typedef enum logic [2:0] {
        ST_FILL,
        ST_EMIT,
        ST_EMIT_FULL_THEN_EMPTY,
        ST_EMIT_LAST,
        ST_DONE
    } state_e;

    // Place a byte into its big-endian lane; lane 0 is bits [63:56].
    function automatic logic [8*WORD_BYTES-1:0] merge_lane(
        input logic [8*WORD_BYTES-1:0] word,
        input logic [7:0]              data_byte,
        input logic [CNT_W-1:0]        lane
    );
        logic [8*WORD_BYTES-1:0] merged;
        merged = word;
        merged[8*(WORD_BYTES-1-int'(lane)) +: 8] = data_byte;
        return merged;
    endfunction

endpackage

// File: rtl/keccak_byte_packer.sv
// Assembly register and lane counter; packs bytes big-endian into a word.
module keccak_byte_packer
    import keccak_feeder_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    accept,
    input  logic                    clear,
    input  logic [7:0]              data_byte,
    output logic [8*WORD_BYTES-1:0] word,
    output logic [CNT_W-1:0]        count
);

    logic [8*WORD_BYTES-1:0] asm_q;
    logic [CNT_W-1:0]        cnt_q;

    // word includes the byte being accepted this cycle so the top can latch a
    // completed word on the same edge.
    always_comb begin
        word  = accept ? merge_lane(asm_q, data_byte, cnt_q) : asm_q;
        count = cnt_q;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    // NOTE: the assembly register is reset and cleared because the zero-fill of
    // a short final word relies on unused lanes already being zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            asm_q <= '0;
            cnt_q <= '0;
        end else if (clear) begin
            asm_q <= '0;
            cnt_q <= '0;
        end else if (accept) begin
            asm_q <= word;
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/keccak_byte_feeder.sv
// Byte-stream front end for the 64-bit keccak core: packs, hands off, pads.
// Optional macro KECCAK_FEEDER_LEN_CNT_EN adds the msg_len byte counter.
module keccak_byte_feeder
    import keccak_feeder_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic [7:0]              s_data,
    input  logic                    s_valid,
    input  logic                    s_last,
    output logic                    s_ready,
    output logic [8*WORD_BYTES-1:0] k_in,
    output logic                    k_in_ready,
    output logic                    k_is_last,
    output logic [BYTE_NUM_W-1:0]   k_byte_num,
    input  logic                    k_buffer_full,
    output logic                    done
`ifdef KECCAK_FEEDER_LEN_CNT_EN
    ,
    output logic [LEN_W-1:0]        msg_len
`endif
);

    if (LEN_W < 4) begin : g_len_w_check
        $error("keccak_byte_feeder: LEN_W must be at least 4");
    end

    state_e                  state_q, state_d;
    logic [8*WORD_BYTES-1:0] k_in_q, k_in_d;
    logic                    k_is_last_q, k_is_last_d;
    logic [BYTE_NUM_W-1:0]   k_byte_num_q, k_byte_num_d;

    logic                    accept;
    logic                    consume;
    logic                    pk_clear;
    logic [8*WORD_BYTES-1:0] pk_word;
    logic [CNT_W-1:0]        pk_count;
    logic [CNT_W-1:0]        new_count;

    // Handshake outputs decode the registered state only, so k_buffer_full
    // never reaches an output combinationally.
    assign s_ready    = (state_q == ST_FILL);
    assign k_in_ready = (state_q == ST_EMIT) || (state_q == ST_EMIT_FULL_THEN_EMPTY)
                     || (state_q == ST_EMIT_LAST);
    assign done       = (state_q == ST_DONE);
    assign k_in       = k_in_q;
    assign k_is_last  = k_is_last_q;
    assign k_byte_num = k_byte_num_q;

    assign accept    = s_valid && s_ready;
    assign consume   = k_in_ready && !k_buffer_full;
    assign new_count = pk_count + 1'b1;

    keccak_byte_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .accept    (accept),
        .clear     (pk_clear),
        .data_byte (s_data),
        .word      (pk_word),
        .count     (pk_count)
    );

    // NOTE: every always_comb output gets a default first so no path through
    // the case statement can infer a latch.
    always_comb begin
        state_d      = state_q;
        k_in_d       = k_in_q;
        k_is_last_d  = k_is_last_q;
        k_byte_num_d = k_byte_num_q;
        pk_clear     = 1'b0;
        unique case (state_q)
            ST_FILL: begin
                if (accept && (s_last || new_count == CNT_W'(WORD_BYTES))) begin
                    pk_clear     = 1'b1;
                    k_in_d       = pk_word;
                    k_is_last_d  = 1'b0;
                    k_byte_num_d = '0;
                    if (!s_last) begin
                        state_d = ST_EMIT;
                    end else if (new_count == CNT_W'(WORD_BYTES)) begin
                        state_d = ST_EMIT_FULL_THEN_EMPTY;
                    end else begin
                        k_is_last_d  = 1'b1;
                        k_byte_num_d = new_count[BYTE_NUM_W-1:0];
                        state_d      = ST_EMIT_LAST;
                    end
                end
            end
            ST_EMIT: begin
                if (consume) state_d = ST_FILL;
            end
            ST_EMIT_FULL_THEN_EMPTY: begin
                // The padder needs an empty terminating word after a whole-word message.
                if (consume) begin
                    k_in_d       = '0;
                    k_is_last_d  = 1'b1;
                    k_byte_num_d = '0;
                    state_d      = ST_EMIT_LAST;
                end
            end
            ST_EMIT_LAST: begin
                if (consume) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (clear) begin
                    pk_clear = 1'b1;
                    state_d  = ST_FILL;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_FILL;
            k_in_q       <= '0;
            k_is_last_q  <= 1'b0;
            k_byte_num_q <= '0;
        end else begin
            state_q      <= state_d;
            k_in_q       <= k_in_d;
            k_is_last_q  <= k_is_last_d;
            k_byte_num_q <= k_byte_num_d;
        end
    end

`ifdef KECCAK_FEEDER_LEN_CNT_EN
    logic [LEN_W-1:0] len_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_q <= '0;
        end else if (done && clear) begin
            len_q <= '0;
        end else if (accept && (len_q != {LEN_W{1'b1}})) begin
            len_q <= len_q + 1'b1;
        end
    end

    assign msg_len = len_q;
`endif

endmodule

// File: tb/tb_keccak_byte_feeder.sv
// Scoreboard bench for keccak_byte_feeder: a model packs each message into
// expected words, a monitor compares every word the DUT hands to keccak.
module tb_keccak_byte_feeder;
    import keccak_feeder_pkg::*;

    localparam int LEN_W  = 16;
    localparam int BUDGET = 200;

    typedef logic [7:0] msg_t[$];

    typedef struct packed {
        logic [63:0] data;
        logic        last;
        logic [2:0]  bnum;
    } word_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clear = 1'b0;
    logic [7:0]  s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        k_buffer_full = 1'b0;
    logic        s_ready;
    logic [63:0] k_in;
    logic        k_in_ready;
    logic        k_is_last;
    logic [2:0]  k_byte_num;
    logic        done;
`ifdef KECCAK_FEEDER_LEN_CNT_EN
    logic [LEN_W-1:0] msg_len;
`endif

    word_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    keccak_byte_feeder #(.LEN_W(LEN_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .clear         (clear),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_last        (s_last),
        .s_ready       (s_ready),
        .k_in          (k_in),
        .k_in_ready    (k_in_ready),
        .k_is_last     (k_is_last),
        .k_byte_num    (k_byte_num),
        .k_buffer_full (k_buffer_full),
        .done          (done)
`ifdef KECCAK_FEEDER_LEN_CNT_EN
        ,
        .msg_len       (msg_len)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference packing: big-endian words, short tail zero-filled, and an extra
    // empty last word when the length is a whole number of words.
    task automatic push_expected(input msg_t msg);
        int len = msg.size();
        for (int w = 0; w * 8 < len; w++) begin
            word_t e;
            int    rem;
            e   = '0;
            rem = len - w * 8;
            for (int b = 0; b < 8; b++)
                if (w * 8 + b < len) e.data[63 - 8 * b -: 8] = msg[w * 8 + b];
            if (rem >= 8) begin
                exp_q.push_back(e);
                if (rem == 8) exp_q.push_back('{data: 64'h0, last: 1'b1, bnum: 3'd0});
            end else begin
                e.last = 1'b1;
                e.bnum = 3'(rem);
                exp_q.push_back(e);
            end
        end
    endtask

    // Monitor: a word pending with no back-pressure is consumed at the next edge.
    always @(negedge clk) begin
        if (reset && k_in_ready && !k_buffer_full) begin
            check("word_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                word_t e;
                e = exp_q.pop_front();
                check("k_in", k_in, e.data);
                check("k_is_last", 64'(k_is_last), 64'(e.last));
                check("k_byte_num", 64'(k_byte_num), 64'(e.bnum));
            end
        end
    end

    task automatic wait_accept();
        int t = 0;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            t++;
            if (t > BUDGET) begin
                check("accept_timeout", 64'(s_ready), 64'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_msg(input msg_t msg, input int clear_at);
        push_expected(msg);
        for (int i = 0; i < msg.size(); i++) begin
            s_valid = 1'b1;
            s_data  = msg[i];
            s_last  = (i == msg.size() - 1);
            clear   = (i == clear_at);
            wait_accept();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        clear   = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (!done && t < BUDGET) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic pulse_clear();
        @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        check("clear_done", 64'(done), 64'd0);
        check("clear_s_ready", 64'(s_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        msg_t m;

        #1;
        check("rst_k_in", k_in, 64'h0);
        check("rst_k_in_ready", 64'(k_in_ready), 64'd0);
        check("rst_k_is_last", 64'(k_is_last), 64'd0);
        check("rst_k_byte_num", 64'(k_byte_num), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_s_ready", 64'(s_ready), 64'd1);
        @(posedge clk);
        #1 reset = 1'b1;

        // Whole-word message: full word then the empty terminating word.
        m = '{8'hfc, 8'h7b, 8'h8c, 8'hda, 8'hfc, 8'h7b, 8'h8c, 8'hda};
        send_msg(m, -1);
        wait_done("msg8");
`ifdef KECCAK_FEEDER_LEN_CNT_EN
        check("msg8_len", 64'(msg_len), 64'd8);
`endif
        s_valid = 1'b1;
        s_data  = 8'h55;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("done_s_ready", 64'(s_ready), 64'd0);
            check("done_hold", 64'(done), 64'd1);
        end
        @(posedge clk);
        #1 s_valid = 1'b0;
        pulse_clear();

        // Short single-word message; clear mid-message must be ignored.
        m = '{8'haa, 8'hbb, 8'hcc};
        send_msg(m, 1);
        wait_done("msg3");
        pulse_clear();

        // 11-byte message with a 5-cycle stall on the first word.
        m = {};
        for (int i = 0; i < 11; i++) m.push_back(8'(i));
        k_buffer_full = 1'b1;
        fork
            send_msg(m, -1);
        join_none
        begin
            int t = 0;
            while (!k_in_ready && t < BUDGET) begin
                @(negedge clk);
                t++;
            end
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_k_in_ready", 64'(k_in_ready), 64'd1);
            check("stall_k_in", k_in, 64'h0001020304050607);
            check("stall_s_ready", 64'(s_ready), 64'd0);
        end
        @(posedge clk);
        #1 k_buffer_full = 1'b0;
        @(posedge clk);
        #1 check("stall_released", 64'(s_ready), 64'd1);
        wait fork;
        wait_done("msg11");
`ifdef KECCAK_FEEDER_LEN_CNT_EN
        check("msg11_len", 64'(msg_len), 64'd11);
`endif
        pulse_clear();
`ifdef KECCAK_FEEDER_LEN_CNT_EN
        check("clear_len", 64'(msg_len), 64'd0);
`endif

        // Reset after 5 bytes aborts the message.
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(8'h30 + i);
            s_last  = 1'b0;
            wait_accept();
        end
        s_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("abort_k_in", k_in, 64'h0);
        check("abort_k_in_ready", 64'(k_in_ready), 64'd0);
        check("abort_k_is_last", 64'(k_is_last), 64'd0);
        check("abort_k_byte_num", 64'(k_byte_num), 64'd0);
        check("abort_done", 64'(done), 64'd0);
`ifdef KECCAK_FEEDER_LEN_CNT_EN
        check("abort_len", 64'(msg_len), 64'd0);
`endif
        @(posedge clk);
        #1 reset = 1'b1;
        m = '{8'hab, 8'hcd};
        send_msg(m, -1);
        wait_done("msg2");
        pulse_clear();

        // A few random-length messages through the same model.
        for (int k = 0; k < 4; k++) begin
            int len;
            len = (k == 0) ? 16 : int'($urandom_range(1, 20));
            m = {};
            for (int i = 0; i < len; i++) m.push_back(8'($urandom));
            send_msg(m, -1);
            wait_done("rand");
`ifdef KECCAK_FEEDER_LEN_CNT_EN
            check("rand_len", 64'(msg_len), 64'(len));
`endif
            pulse_clear();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keccak_byte_feeder.md
Name: keccak_byte_feeder

Overview:
- Upstream stage of the 64-bit-input `keccak` core.
- Accepts a byte stream with valid/ready/last handshake.
- Packs bytes big-endian into 64-bit words and drives keccak's `in`/`in_ready`/`is_last`/`byte_num`, stalling on `buffer_full`.
- Used by the Kyber hash wrappers (G/H) to present arbitrary-length messages without per-caller word packing.

Parameters:
- LEN_W, 16, width of the message byte counter (used only with the optional feature).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- clear  input  1  sync pulse; leaves DONE, starts a new message. Issued together with the keccak core reset.
- s_data  input  8  message byte.
- s_valid  input  1  byte valid.
- s_last  input  1  byte is the final message byte.
- s_ready  output  1  byte accepted when s_valid & s_ready.
- k_in  output  64  word to keccak; first byte in [63:56].
- k_in_ready  output  1  word pending (drives keccak in_ready).
- k_is_last  output  1  drives keccak is_last.
- k_byte_num  output  3  valid bytes in the final word (drives keccak byte_num).
- k_buffer_full  input  1  from keccak buffer_full.
- done  output  1  final word consumed; waiting for clear.

Behaviour:
- Reset (reset=0, asynchronous):
  - state FILL, count=0.
  - k_in=0, k_in_ready=0, k_is_last=0, k_byte_num=0, done=0.
  - Assembly register is zeroed.
  - Reset mid-operation aborts the message; the pending word is dropped.
- Word consumption: a word is consumed on a rising edge with k_in_ready=1 and k_buffer_full=0.
  - While unconsumed, k_in, k_is_last and k_byte_num hold stable.
  - No combinational path from k_buffer_full to any output.
- States:
  - FILL:
    - s_ready=1. On accept, byte goes to lane (7-count), count++.
    - Accept with count==7 and !s_last → EMIT: full word, k_is_last=0, count←0.
    - Accept with s_last and new count n<8 → EMIT_LAST: k_is_last=1, k_byte_num=n, unused low bytes zero.
    - Accept with s_last and n==8 → EMIT_FULL_THEN_EMPTY: full word, k_is_last=0.
  - EMIT: s_ready=0, k_in_ready=1. On consume → FILL.
  - EMIT_FULL_THEN_EMPTY: s_ready=0. On consume, load k_in=0, k_is_last=1, k_byte_num=0 → EMIT_LAST. Keccak's padder requires this empty terminating word when length ≡ 0 mod 8.
  - EMIT_LAST: s_ready=0. On consume → DONE.
  - DONE: done=1, s_ready=0, k_in_ready=0. On clear → FILL, count=0, assembly zeroed.
  - clear in any state other than DONE: ignored.
- Latency: the word is presented the cycle after the accepting edge of its 8th (or last) byte. Throughput with no stall is 8 bytes per 9 cycles.
- Empty messages are not supported. s_last must accompany at least one byte; Kyber never hashes zero-length input.
- s_valid while s_ready=0: byte not taken; the source holds it.

Optional Feature:
- Macro KECCAK_FEEDER_LEN_CNT_EN.
- Defined:
  - Adds output msg_len [LEN_W-1:0]: bytes accepted in the current message.
  - Reset and clear set it to 0; increments per accepted byte; saturates at all-ones.
  - Holds its value in DONE.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package keccak_feeder_pkg:
  - state encoding (FILL, EMIT, EMIT_FULL_THEN_EMPTY, EMIT_LAST, DONE);
  - WORD_BYTES=8;
  - BYTE_NUM_W=3.
- One natural sub-module: keccak_byte_packer.
  - Contents: assembly register, lane counter, zero-fill.
  - Ports: accept, byte, clear; outputs word, count.
- The FSM and handshake stay in the top.

Test Plan:
- 8-byte message: bytes fc 7b 8c da fc 7b 8c da, last on byte 8.
  - Word fc7b8cdafc7b8cda with is_last=0, then word 0 with is_last=1, byte_num=0.
  - done=1 afterwards.
  - Chained into keccak, out = 58a5422d…d8ea008e.
- 3-byte message: aa bb cc, last on cc → k_in=aabbcc0000000000, k_is_last=1, k_byte_num=3, a single word.
- 11-byte message: 00..0a → word 0001020304050607 (is_last=0), then 08090a0000000000 (is_last=1, byte_num=3).
- Stall: hold k_buffer_full=1 for 5 cycles with a word pending → k_in_ready stays 1, k_in stable, s_ready=0; consumed on the first edge with k_buffer_full=0.
- Reset and clear:
  - Assert reset after 5 bytes → all outputs 0 immediately; a subsequent 2-byte message ab cd yields abcd000000000000, byte_num=2.
  - In DONE, s_valid=1 is not accepted until clear is pulsed.
- With KECCAK_FEEDER_LEN_CNT_EN, the 11-byte message gives msg_len=11 in DONE, and 0 after clear.
